// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
//   sb_entry_t : scoreboard entry {wb, mem, dest} at the default 4-bit register address
//   hz_state_t : controller states RUN / FLUSH / MEM_WAIT
//   MEM_POS    : scoreboard slot that corresponds to the MEM stage
package hazard_pkg;
    localparam int HZ_ADDR_LEN = 4;
    localparam int MEM_POS = 1;
    typedef struct packed {
        logic                   wb;
        logic                   mem;
        logic [HZ_ADDR_LEN-1:0] dest;
    } sb_entry_t;
    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} hz_state_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register record of in-flight register writes with two RAW comparators
//   clk, rst         : clock, asynchronous active-low reset
//   i_freeze         : hold every entry this edge
//   i_issue          : ID instruction enters EXE this edge (otherwise a bubble enters)
//   i_wb_en, i_mem_en, i_dest : fields of the issuing instruction
//   i_src1, i_src2   : source registers to compare
//   o_match1/2       : some pending writer targets src1/src2
//   o_mem_busy       : the entry in the MEM slot is a load/store
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_LEN = 4,
    parameter int DEPTH    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_freeze,
    input  logic                i_issue,
    input  logic                i_wb_en,
    input  logic                i_mem_en,
    input  logic [ADDR_LEN-1:0] i_dest,
    input  logic [ADDR_LEN-1:0] i_src1,
    input  logic [ADDR_LEN-1:0] i_src2,
    output logic                o_match1,
    output logic                o_match2,
    output logic                o_mem_busy
);
    typedef struct packed {
        logic                wb;
        logic                mem;
        logic [ADDR_LEN-1:0] dest;
    } entry_t;

    entry_t r_sb [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_sb[i] <= '0;
        end else if (!i_freeze) begin
            r_sb[0] <= i_issue ? entry_t'({i_wb_en, i_mem_en, i_dest}) : '0;
            for (int i = 1; i < DEPTH; i++) r_sb[i] <= r_sb[i-1];
        end
    end

    always_comb begin
        o_match1 = 1'b0;
        o_match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            o_match1 |= r_sb[i].wb & (r_sb[i].dest == i_src1);
            o_match2 |= r_sb[i].wb & (r_sb[i].dest == i_src2);
        end
    end

    assign o_mem_busy = r_sb[MEM_POS].mem;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: RAW stall, branch flush and memory freeze control beside the ID stage
//   clk, rst                 : clock, asynchronous active-low reset
//   id_valid                 : ID holds a real instruction
//   id_src1/2, id_use1/2     : source registers and whether they are read
//   id_dest, id_wb_en, id_mem_en : destination and control of the ID instruction
//   br_taken                 : ID branch condition true
//   mem_ready                : data memory completes this cycle
//   hazard_detected          : RAW stall, ID sends a bubble to EXE
//   freeze_if                : hold PC and IF/ID
//   flush_if_id              : clear IF/ID at the next edge
//   freeze_all               : hold every pipeline register and the scoreboard
//   stall_cnt                : saturating count of RAW stall cycles
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_LEN     = 4,
    parameter int DEPTH        = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [ADDR_LEN-1:0] id_src1,
    input  logic [ADDR_LEN-1:0] id_src2,
    input  logic                id_use1,
    input  logic                id_use2,
    input  logic [ADDR_LEN-1:0] id_dest,
    input  logic                id_wb_en,
    input  logic                id_mem_en,
    input  logic                br_taken,
    input  logic                mem_ready,
    output logic                hazard_detected,
    output logic                freeze_if,
    output logic                flush_if_id,
    output logic                freeze_all,
    output logic [CNT_W-1:0]    stall_cnt
);
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    hz_state_t       r_state, w_state_next, r_ret, w_ret_next;
    logic [FC_W-1:0] r_fcnt, w_fcnt_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic            w_match1, w_match2, w_mem_busy, w_mem_stall, w_issue;

    hazard_scoreboard #(.ADDR_LEN(ADDR_LEN), .DEPTH(DEPTH)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_freeze   (freeze_all),
        .i_issue    (w_issue),
        .i_wb_en    (id_wb_en),
        .i_mem_en   (id_mem_en),
        .i_dest     (id_dest),
        .i_src1     (id_src1),
        .i_src2     (id_src2),
        .o_match1   (w_match1),
        .o_match2   (w_match2),
        .o_mem_busy (w_mem_busy)
    );

    assign hazard_detected = id_valid & ((id_use1 & w_match1) | (id_use2 & w_match2));
    assign w_mem_stall     = w_mem_busy & ~mem_ready;
    assign w_issue         = id_valid & ~hazard_detected & ~flush_if_id;
    assign freeze_if       = hazard_detected | freeze_all;
    assign stall_cnt       = r_stall_cnt;

    always_comb begin
        w_state_next = r_state;
        w_ret_next   = r_ret;
        w_fcnt_next  = r_fcnt;
        freeze_all   = 1'b0;
        flush_if_id  = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    freeze_all   = 1'b1;
                    w_state_next = MEM_WAIT;
                    w_ret_next   = RUN;
                end else if (br_taken & id_valid & ~hazard_detected) begin
                    flush_if_id = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_next = FLUSH;
                        w_fcnt_next  = FC_W'(FLUSH_CYCLES - 1);
                    end
                end
            end
            FLUSH: begin
                flush_if_id = 1'b1;
                // a memory stall parks the flush with its remaining count intact
                if (w_mem_stall) begin
                    w_state_next = MEM_WAIT;
                    w_ret_next   = FLUSH;
                end else begin
                    w_fcnt_next  = r_fcnt - 1'b1;
                    w_state_next = (r_fcnt == FC_W'(1)) ? RUN : FLUSH;
                end
            end
            MEM_WAIT: begin
                freeze_all   = 1'b1;
                w_state_next = mem_ready ? r_ret : MEM_WAIT;
            end
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_ret       <= RUN;
            r_fcnt      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_ret   <= w_ret_next;
            r_fcnt  <= w_fcnt_next;
            if (hazard_detected & ~freeze_all & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit (DEPTH=3, FLUSH_CYCLES=2, CNT_W=3)
module tb_hazard_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use1, id_use2, id_wb_en, id_mem_en, br_taken, mem_ready;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       hazard_detected, freeze_if, flush_if_id, freeze_all;
    logic [2:0] stall_cnt;
    int         checks = 0;
    int         errors = 0;

    hazard_unit #(.ADDR_LEN(4), .DEPTH(3), .FLUSH_CYCLES(2), .CNT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_use1         (id_use1),
        .id_use2         (id_use2),
        .id_dest         (id_dest),
        .id_wb_en        (id_wb_en),
        .id_mem_en       (id_mem_en),
        .br_taken        (br_taken),
        .mem_ready       (mem_ready),
        .hazard_detected (hazard_detected),
        .freeze_if       (freeze_if),
        .flush_if_id     (flush_if_id),
        .freeze_all      (freeze_all),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_valid = 0; id_use1 = 0; id_use2 = 0; id_wb_en = 0; id_mem_en = 0;
        br_taken = 0; mem_ready = 1; id_src1 = 0; id_src2 = 0; id_dest = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0;
        idle();
        tick();
        tick();
        rst = 1;
    endtask

    task automatic writer(input logic [3:0] d, input logic m);
        idle();
        id_valid = 1; id_wb_en = 1; id_mem_en = m; id_dest = d;
    endtask

    task automatic reader(input logic [3:0] s1, input logic u1, input logic [3:0] s2, input logic u2);
        idle();
        id_valid = 1; id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        @(negedge clk);
        checks++;
        if ({hazard_detected, freeze_if, flush_if_id, freeze_all} !== 4'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0000", {hazard_detected, freeze_if, flush_if_id, freeze_all});
        end
        checks++;
        if (stall_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        tick();
        rst = 1;
        writer(4'd3, 0);
        tick();
        reader(4'd3, 1, 4'd0, 0);
        tick();
        #2;
        checks++;
        if (hazard_detected !== 1'b1) begin errors++; $display("FAIL reset_pre_hazard: got %b want 1", hazard_detected); end
        rst = 0;
        #1;
        checks++;
        if (hazard_detected !== 1'b0 || stall_cnt !== 3'd0) begin
            errors++; $display("FAIL reset_mid_op: hazard %b cnt %0d want 0 0", hazard_detected, stall_cnt);
        end
        rst = 1;
        tick();
        @(negedge clk);
        checks++;
        if (hazard_detected !== 1'b0) begin errors++; $display("FAIL reset_sb_empty: got %b want 0", hazard_detected); end
        tick();
    endtask

    task automatic test_raw();
        do_reset();
        writer(4'd3, 0);
        @(negedge clk);
        checks++;
        if (hazard_detected !== 1'b0) begin errors++; $display("FAIL raw_writer: got %b want 0", hazard_detected); end
        tick();
        reader(4'd3, 1, 4'd0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (hazard_detected !== 1'b1 || freeze_if !== 1'b1 || freeze_all !== 1'b0) begin
                errors++; $display("FAIL raw_stall%0d: hz %b fi %b fa %b want 1 1 0", k, hazard_detected, freeze_if, freeze_all);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (hazard_detected !== 1'b0 || stall_cnt !== 3'd3) begin
            errors++; $display("FAIL raw_release: hz %b cnt %0d want 0 3", hazard_detected, stall_cnt);
        end
        tick();
        idle();
    endtask

    task automatic test_no_dep();
        do_reset();
        writer(4'd3, 0);
        tick();
        reader(4'd4, 1, 4'd5, 1);
        @(negedge clk);
        checks++;
        if (hazard_detected !== 1'b0) begin errors++; $display("FAIL nodep_r4r5: got %b want 0", hazard_detected); end
        tick();
        reader(4'd4, 1, 4'd3, 0);
        @(negedge clk);
        checks++;
        if (hazard_detected !== 1'b0) begin errors++; $display("FAIL nodep_use2_off: got %b want 0", hazard_detected); end
        reader(4'd4, 1, 4'd3, 1);
        #1;
        checks++;
        if (hazard_detected !== 1'b1) begin errors++; $display("FAIL dep_use2_on: got %b want 1", hazard_detected); end
        reader(4'd3, 1, 4'd0, 0);
        id_valid = 0;
        #1;
        checks++;
        if (hazard_detected !== 1'b0) begin errors++; $display("FAIL nodep_bubble: got %b want 0", hazard_detected); end
        tick();
        writer(4'hF, 0);
        tick();
        reader(4'hF, 1, 4'd0, 0);
        @(negedge clk);
        checks++;
        if (hazard_detected !== 1'b1) begin errors++; $display("FAIL raw_r15: got %b want 1", hazard_detected); end
        tick();
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        idle();
        id_valid = 1; br_taken = 1;
        @(negedge clk);
        checks++;
        if (flush_if_id !== 1'b1 || freeze_if !== 1'b0) begin
            errors++; $display("FAIL br_flush0: flush %b fi %b want 1 0", flush_if_id, freeze_if);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (flush_if_id !== 1'b1) begin errors++; $display("FAIL br_flush1: got %b want 1", flush_if_id); end
        tick();
        @(negedge clk);
        checks++;
        if (flush_if_id !== 1'b0) begin errors++; $display("FAIL br_done: got %b want 0", flush_if_id); end
        id_valid = 1; br_taken = 1;
        #1;
        checks++;
        if (flush_if_id !== 1'b1) begin errors++; $display("FAIL br_rerun: got %b want 1", flush_if_id); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_branch_hazard();
        do_reset();
        writer(4'd3, 0);
        tick();
        reader(4'd3, 1, 4'd0, 0);
        br_taken = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (hazard_detected !== 1'b1 || flush_if_id !== 1'b0) begin
                errors++; $display("FAIL brhz_stall%0d: hz %b flush %b want 1 0", k, hazard_detected, flush_if_id);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (hazard_detected !== 1'b0 || flush_if_id !== 1'b1) begin
            errors++; $display("FAIL brhz_release: hz %b flush %b want 0 1", hazard_detected, flush_if_id);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (flush_if_id !== 1'b1) begin errors++; $display("FAIL brhz_flush1: got %b want 1", flush_if_id); end
        tick();
    endtask

    task automatic test_mem_stall();
        logic mr [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        logic fz [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
        logic hz [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        do_reset();
        writer(4'd5, 1);
        tick();
        for (int c = 0; c < 8; c++) begin
            reader(4'd5, 1, 4'd0, 0);
            mem_ready = mr[c];
            @(negedge clk);
            checks++;
            if (hazard_detected !== hz[c] || freeze_all !== fz[c] || freeze_if !== (hz[c] | fz[c])) begin
                errors++;
                $display("FAIL mem_c%0d: hz %b fa %b fi %b want %b %b %b", c, hazard_detected, freeze_all, freeze_if, hz[c], fz[c], hz[c] | fz[c]);
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 3'd3) begin errors++; $display("FAIL mem_cnt: got %0d want 3", stall_cnt); end
        idle();
    endtask

    task automatic test_saturation();
        logic [2:0] exp_cnt [3] = '{0, 3, 6};
        do_reset();
        for (int n = 0; n < 3; n++) begin
            writer(4'd3, 0);
            @(negedge clk);
            checks++;
            if (stall_cnt !== exp_cnt[n]) begin errors++; $display("FAIL sat_iter%0d: got %0d want %0d", n, stall_cnt, exp_cnt[n]); end
            tick();
            reader(4'd3, 1, 4'd0, 0);
            repeat (3) tick();
        end
        idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_final: got %0d want 7", stall_cnt); end
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        writer(4'd6, 1);
        tick();
        idle();
        mem_ready = 0;
        tick();
        @(negedge clk);
        checks++;
        if (freeze_all !== 1'b1) begin errors++; $display("FAIL midrst_enter: got %b want 1", freeze_all); end
        tick();
        #1;
        checks++;
        if (freeze_all !== 1'b1) begin errors++; $display("FAIL midrst_wait: got %b want 1", freeze_all); end
        rst = 0;
        #1;
        checks++;
        if (freeze_all !== 1'b0 || freeze_if !== 1'b0) begin
            errors++; $display("FAIL midrst_memwait: fa %b fi %b want 0 0", freeze_all, freeze_if);
        end
        rst = 1;
        tick();
        @(negedge clk);
        checks++;
        if (freeze_all !== 1'b0) begin errors++; $display("FAIL midrst_run: got %b want 0", freeze_all); end
        tick();
        idle();
        id_valid = 1; br_taken = 1;
        tick();
        idle();
        #1;
        checks++;
        if (flush_if_id !== 1'b1) begin errors++; $display("FAIL midrst_in_flush: got %b want 1", flush_if_id); end
        rst = 0;
        #1;
        checks++;
        if (flush_if_id !== 1'b0) begin errors++; $display("FAIL midrst_flush: got %b want 0", flush_if_id); end
        rst = 1;
        tick();
        @(negedge clk);
        checks++;
        if (flush_if_id !== 1'b0) begin errors++; $display("FAIL midrst_after_flush: got %b want 0", flush_if_id); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        test_reset();
        test_raw();
        test_no_dep();
        test_branch();
        test_branch_hazard();
        test_mem_stall();
        test_saturation();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
